// File: rtl/if_fetch_unit_if.sv
// Instruction-memory channel between the fetch unit and instruction memory.
//   imem_req_valid/ready/addr : in-order word fetch requests (fetch -> memory)
//   imem_rsp_valid/data       : in-order response words, >=1 cycle after accept
// master = fetch unit, slave = instruction memory.
interface if_fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues in-order word fetches over
// the imem channel, buffers returned words in a DEPTH-entry FIFO and presents
// the head to decode. A redirect flushes the FIFO and squashes responses that
// are still in flight.
//   clk, rst        : clock, synchronous active-high reset
//   imem            : memory channel (master side)
//   redirect_valid  : one-cycle taken jump/branch pulse
//   redirect_pc     : target, bits [1:0] ignored
//   stall           : decode cannot accept, FIFO head is held
//   instr_valid     : FIFO head valid
//   instr, instr_pc : FIFO head word and its address
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  if_fetch_unit_if.master        imem,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   stall,
  output logic                   instr_valid,
  output logic [31:0]            instr,
  output logic [31:0]            instr_pc
);
  localparam int          PW      = $clog2(DEPTH);
  localparam int          CW      = $clog2(DEPTH) + 1;  // holds 0..DEPTH
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } fifo_ent_t;

  logic [31:0]   pc, rsp_pc, redir_tgt;
  logic [CW-1:0] inflight, drop_cnt, count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  fifo_ent_t     mem [DEPTH];
  logic          pop, req_fire, push;
  logic [CW:0]   credit;
  logic          unused_bits;

  assign redir_tgt   = {redirect_pc[31:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  assign pop      = instr_valid & ~stall;
  assign req_fire = imem.imem_req_valid & imem.imem_req_ready;

  // Every outstanding request reserves a FIFO slot, so a response that is
  // not squashed always has room. A pop this cycle frees a slot early,
  // which is what lets requests resume the same cycle stall drops.
  assign credit = {1'b0, inflight} + {1'b0, count} - {{CW{1'b0}}, pop};
  assign imem.imem_req_valid = ~rst & ~redirect_valid & (credit < DEPTH_W);
  assign imem.imem_req_addr  = pc;

  // Responses are squashed while drop_cnt is nonzero (pre-redirect requests)
  // and in the redirect cycle itself.
  assign push = imem.imem_rsp_valid & ~redirect_valid & (drop_cnt == '0);

  // Head comes straight from FIFO storage flops; the read slot is never
  // rewritten while occupied, so instr/instr_pc hold under stall.
  assign instr_valid = (count != '0);
  assign instr       = mem[rd_ptr].data;
  assign instr_pc    = mem[rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '{pc: RESET_PC, data: NOP};
    end else if (redirect_valid) begin
      // No request fires this cycle; everything still outstanding after
      // this cycle's response (itself dropped) must be discarded.
      pc       <= redir_tgt;
      rsp_pc   <= redir_tgt;
      inflight <= inflight - CW'(imem.imem_rsp_valid);
      drop_cnt <= inflight - CW'(imem.imem_rsp_valid);
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      inflight <= inflight + CW'(req_fire) - CW'(imem.imem_rsp_valid);
      if (imem.imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
      if (push) begin
        mem[wr_ptr] <= '{pc: rsp_pc, data: imem.imem_rsp_data};
        wr_ptr      <= wr_ptr + 1'b1;
        rsp_pc      <= rsp_pc + 32'd4;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && count == DEPTH_C));
  a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
    inflight <= DEPTH_C);
endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;

  if_fetch_unit_if imem();

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  logic [31:0] exp_pc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_1230;
  endfunction

  // Instruction memory: in-order, per-request latency lat_min..lat_max,
  // optional random ready, reset together with the DUT.
  typedef struct { logic [31:0] addr; int due; } pend_t;
  pend_t mem_q[$];
  int    cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
  bit    rand_rdy = 1'b0;

  initial begin
    int d;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = 32'h0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mem_q.delete();
        last_due = 0;
      end else begin
        if (imem.imem_rsp_valid) void'(mem_q.pop_front());
        if (imem.imem_req_valid && imem.imem_req_ready) begin
          d = cyc + int'($urandom_range(lat_max, lat_min));
          if (d <= last_due) d = last_due + 1;
          last_due = d;
          mem_q.push_back('{imem.imem_req_addr, d});
        end
      end
      #1;
      cyc++;
      imem.imem_req_ready = rand_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        imem.imem_rsp_valid = 1'b1;
        imem.imem_rsp_data  = word(mem_q[0].addr);
      end else begin
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'h0;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (2) tick();
    @(negedge clk);
    n_chk++; if ({imem.imem_req_valid, instr_valid} !== 2'b00) $display("FAIL reset_valids: got req_valid/instr_valid=%b want 00", {imem.imem_req_valid, instr_valid}); else n_pass++;
    n_chk++; if (instr !== 32'h0000_0013) $display("FAIL reset_instr: got %h want 00000013", instr); else n_pass++;
    n_chk++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h want 00000000", instr_pc); else n_pass++;
    n_chk++; if (imem.imem_req_addr !== 32'h0) $display("FAIL reset_req_addr: got %h want 00000000", imem.imem_req_addr); else n_pass++;
  endtask

  task automatic test_stream;
    tick(); rst = 1'b0; exp_pc = 32'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h0}) $display("FAIL first_req: got valid=%b addr=%h want 1 00000000", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
      end
      if (c < 2) begin
        n_chk++; if (instr_valid !== 1'b0) $display("FAIL stream_latency c%0d: got instr_valid=%b want 0", c, instr_valid); else n_pass++;
      end else begin
        n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word(exp_pc)}) $display("FAIL stream c%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", c, instr_valid, instr_pc, instr, exp_pc, word(exp_pc)); else n_pass++;
        exp_pc += 32'd4;
      end
      tick();
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word(exp_pc)}) $display("FAIL stall_hold k%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, instr_valid, instr_pc, instr, exp_pc, word(exp_pc)); else n_pass++;
      n_chk++; if (imem.imem_req_valid !== 1'b0) $display("FAIL stall_no_req k%0d: got req_valid=%b want 0", k, imem.imem_req_valid); else n_pass++;
      if (k == 4) begin
        n_chk++; if (int'(dut.count) !== DEPTH) $display("FAIL stall_full: got count=%0d want %0d", dut.count, DEPTH); else n_pass++;
      end
      tick();
    end
    stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (imem.imem_req_valid !== 1'b1) $display("FAIL stall_resume_req: got req_valid=%b want 1", imem.imem_req_valid); else n_pass++;
      end
      n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word(exp_pc)}) $display("FAIL stall_resume k%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, instr_valid, instr_pc, instr, exp_pc, word(exp_pc)); else n_pass++;
      exp_pc += 32'd4;
      tick();
    end
  endtask

  task automatic test_redirect_fast;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    @(negedge clk);
    n_chk++; if (imem.imem_req_valid !== 1'b0) $display("FAIL redir_no_req_N: got req_valid=%b want 0", imem.imem_req_valid); else n_pass++;
    tick(); redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL redir_flush_N1: got instr_valid=%b want 0", instr_valid); else n_pass++;
    n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h80}) $display("FAIL redir_target_req: got valid=%b addr=%h want 1 00000080", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL redir_N2: got instr_valid=%b want 0", instr_valid); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h80, word(32'h80)}) $display("FAIL redir_N3: got v=%b pc=%h instr=%h want v=1 pc=00000080 instr=%h", instr_valid, instr_pc, instr, word(32'h80)); else n_pass++;
    exp_pc = 32'h84;
    tick();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word(exp_pc)}) $display("FAIL redir_follow k%0d: got v=%b pc=%h want v=1 pc=%h", k, instr_valid, instr_pc, exp_pc); else n_pass++;
      exp_pc += 32'd4;
      tick();
    end
  endtask

  task automatic test_redirect_inflight;
    bit found = 1'b0, got = 1'b0;
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 12 && !found; i++) begin
      tick();
      if (mem_q.size() == DEPTH) found = 1'b1;
    end
    n_chk++; if (!found) $display("FAIL inflight_setup: got outstanding=%0d want %0d", mem_q.size(), DEPTH); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick(); redirect_valid = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        n_chk++; if ({instr_pc, instr} !== {32'h100, word(32'h100)}) $display("FAIL inflight_first: got pc=%h instr=%h want pc=00000100 instr=%h", instr_pc, instr, word(32'h100)); else n_pass++;
        exp_pc = 32'h104;
      end
      tick();
    end
    n_chk++; if (!got) $display("FAIL inflight_timeout: got no valid instr want pc=00000100"); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        n_chk++; if ({instr_pc, instr} !== {exp_pc, word(exp_pc)}) $display("FAIL inflight_follow: got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, exp_pc, word(exp_pc)); else n_pass++;
        exp_pc += 32'd4;
      end
      tick();
    end
    lat_min = 1; lat_max = 1;
  endtask

  task automatic test_flush_priority;
    bit seen = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 10 && !seen; i++) begin
      tick(); #1;
      if (imem.imem_rsp_valid) seen = 1'b1;
    end
    n_chk++; if (!seen) $display("FAIL flush_setup: got no response want rsp_valid=1"); else n_pass++;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; stall = 1'b1;
    @(negedge clk);
    n_chk++; if (imem.imem_req_valid !== 1'b0) $display("FAIL flush_no_req_N: got req_valid=%b want 0", imem.imem_req_valid); else n_pass++;
    tick(); redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
    @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL flush_wins: got instr_valid=%b want 0", instr_valid); else n_pass++;
    n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h200}) $display("FAIL flush_align: got valid=%b addr=%h want 1 00000200", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL flush_N2: got instr_valid=%b want 0", instr_valid); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h200, word(32'h200)}) $display("FAIL flush_N3: got v=%b pc=%h instr=%h want v=1 pc=00000200 instr=%h", instr_valid, instr_pc, instr, word(32'h200)); else n_pass++;
    exp_pc = 32'h204;
    tick();
  endtask

  task automatic test_random;
    bit          prev_pend = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int          pops = 0;
    rand_rdy = 1'b1; lat_min = 1; lat_max = 3;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000; stall = 1'b0;
    tick(); redirect_valid = 1'b0; redirect_pc = 32'h0; exp_pc = 32'h1000;
    for (int i = 0; i < 200; i++) begin
      stall = ($urandom_range(3, 0) == 0);
      @(negedge clk);
      if (prev_pend) begin
        n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, prev_addr}) $display("FAIL rand_addr_stable i%0d: got valid=%b addr=%h want 1 %h", i, imem.imem_req_valid, imem.imem_req_addr, prev_addr); else n_pass++;
      end
      n_chk++; if (mem_q.size() > DEPTH) $display("FAIL rand_outstanding i%0d: got %0d want <=%0d", i, mem_q.size(), DEPTH); else n_pass++;
      if (instr_valid && !stall) begin
        n_chk++; if ({instr_pc, instr} !== {exp_pc, word(exp_pc)}) $display("FAIL rand_order i%0d: got pc=%h instr=%h want pc=%h instr=%h", i, instr_pc, instr, exp_pc, word(exp_pc)); else n_pass++;
        exp_pc += 32'd4;
        pops++;
      end
      prev_pend = imem.imem_req_valid && !imem.imem_req_ready;
      prev_addr = imem.imem_req_addr;
      tick();
    end
    stall = 1'b0; rand_rdy = 1'b0; lat_min = 1; lat_max = 1;
    n_chk++; if (pops < 30) $display("FAIL rand_progress: got %0d pops want >=30", pops); else n_pass++;
  endtask

  task automatic test_wrap;
    repeat (6) tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick(); redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(negedge clk);
    n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'hFFFF_FFF8}) $display("FAIL wrap_req0: got valid=%b addr=%h want 1 fffffff8", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_req1: got valid=%b addr=%h want 1 fffffffc", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_req2: got valid=%b addr=%h want 1 00000000", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    exp_pc = 32'hFFFF_FFF8;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word(exp_pc)}) $display("FAIL wrap_stream k%0d: got v=%b pc=%h want v=1 pc=%h", k, instr_valid, instr_pc, exp_pc); else n_pass++;
      exp_pc += 32'd4;
      tick();
    end
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (imem.imem_req_valid !== 1'b0) $display("FAIL rst_mid_req: got req_valid=%b want 0", imem.imem_req_valid); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if ({instr_valid, instr, instr_pc, imem.imem_req_addr} !== {1'b0, 32'h13, 32'h0, 32'h0}) $display("FAIL rst_mid_outputs: got v=%b instr=%h pc=%h addr=%h want 0 00000013 00000000 00000000", instr_valid, instr, instr_pc, imem.imem_req_addr); else n_pass++;
    tick(); rst = 1'b0;
    @(negedge clk);
    n_chk++; if ({imem.imem_req_valid, imem.imem_req_addr} !== {1'b1, 32'h0}) $display("FAIL rst_mid_restart: got valid=%b addr=%h want 1 00000000", imem.imem_req_valid, imem.imem_req_addr); else n_pass++;
    tick(); @(negedge clk);
    n_chk++; if (instr_valid !== 1'b0) $display("FAIL rst_mid_c1: got instr_valid=%b want 0", instr_valid); else n_pass++;
    exp_pc = 32'h0;
    for (int k = 0; k < 3; k++) begin
      tick(); @(negedge clk);
      n_chk++; if ({instr_valid, instr_pc, instr} !== {1'b1, exp_pc, word(exp_pc)}) $display("FAIL rst_mid_stream k%0d: got v=%b pc=%h want v=1 pc=%h", k, instr_valid, instr_pc, exp_pc); else n_pass++;
      exp_pc += 32'd4;
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_fast();
    test_redirect_inflight();
    test_flush_priority();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
